// File: rtl/vga_text_renderer_pkg.sv
//==============================================================================
// Module      : vga_text_renderer_pkg
// Description : Shared geometry and colour constants for the VGA text renderer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package vga_text_renderer_pkg;

    localparam int          c_cols       = 80;
    localparam int          c_rows       = 30;
    localparam int          c_glyph_w    = 8;
    localparam int          c_glyph_h    = 16;
    localparam int          c_text_depth = c_cols * c_rows;
    localparam logic [11:0] c_fg_rgb     = 12'hFFF;
    localparam logic [11:0] c_bg_rgb     = 12'h000;
    localparam logic [7:0]  c_blank_char = 8'h20;

endpackage

`default_nettype wire

// File: rtl/vga_text_renderer_font_rom_8x16.sv
//==============================================================================
// Module      : font_rom_8x16
// Description : 128-glyph 8x16 font ROM, one registered glyph row per enabled clock.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module font_rom_8x16
    import vga_text_renderer_pkg::*;
(
    input  logic       clk_100MHz,
    input  logic       i_en,
    input  logic [6:0] i_char,
    input  logic [3:0] i_row,
    output logic [7:0] o_data
);

    localparam int c_bits = c_glyph_w * c_glyph_h;

    // Glyph row 0 occupies the top byte; printable codes without artwork render as a hollow box.
    localparam logic [c_bits-1:0] c_glyph_a   = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [c_bits-1:0] c_glyph_b   = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
    localparam logic [c_bits-1:0] c_glyph_box = 128'h0000_7E42_4242_4242_4242_4242_427E_0000;

    logic [c_bits-1:0] w_glyph;
    logic [7:0]        r_data;

    always_comb begin
        w_glyph = '0;
        case (i_char)
            7'h41:   w_glyph = c_glyph_a;
            7'h42:   w_glyph = c_glyph_b;
            default: begin
                if (i_char > 7'h20 && i_char < 7'h7F) begin
                    w_glyph = c_glyph_box;
                end
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (i_en) begin
            r_data <= w_glyph[{~i_row, 3'b000} +: 8];
        end
    end

    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/vga_text_renderer.sv
//==============================================================================
// Module      : vga_text_renderer
// Description : 80x30 text-mode pixel generator with blinking cursor, 3-tick pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_text_renderer
    import vga_text_renderer_pkg::*;
#(
    parameter int          COLS       = c_cols,
    parameter int          ROWS       = c_rows,
    parameter logic [11:0] FG_RGB     = c_fg_rgb,
    parameter logic [11:0] BG_RGB     = c_bg_rgb,
    parameter int          BLINK_BITS = 5
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    localparam logic [6:0]  c_cols_lim = 7'(COLS);
    localparam logic [4:0]  c_rows_lim = 5'(ROWS);
    localparam logic [11:0] c_depth    = 12'(c_text_depth);

    logic [6:0]  w_col;
    logic [4:0]  w_row;
    logic [11:0] w_rd_addr;
    logic [11:0] w_rd_addr_safe;
    logic        w_cursor_hit;
    logic [7:0]  w_char;
    logic [7:0]  w_glyph_row;
    logic        w_blink_phase;
    logic        w_pix;

    logic [7:0]  r_text_mem [0:c_text_depth-1];
    logic [7:0]  r_ram_q;
    logic [2:0]  r_s1_xbit;
    logic [3:0]  r_s1_yrow;
    logic        r_s1_von, r_s1_hs, r_s1_vs, r_s1_cursor;
    logic [2:0]  r_s2_xbit;
    logic        r_s2_inv, r_s2_von, r_s2_hs, r_s2_vs, r_s2_cursor;
    logic [11:0] r_rgb;
    logic        r_hsync, r_vsync;
    logic        r_vsync_prev;
    logic [BLINK_BITS-1:0] r_frame_cnt;

    assign w_col     = x[9:3];
    assign w_row     = y[8:4];
    assign w_rd_addr = {1'b0, w_row, 6'b000000} + {3'b000, w_row, 4'b0000} + {5'b00000, w_col};
    // Off-screen coordinates are blanked downstream; just keep the read index in bounds.
    assign w_rd_addr_safe = (y[9] || (w_rd_addr >= c_depth)) ? 12'd0 : w_rd_addr;
    assign w_cursor_hit   = cursor_en && (cursor_col < c_cols_lim) && (cursor_row < c_rows_lim)
                            && (w_col == cursor_col) && (w_row == cursor_row);

    // Cells are stored XOR'd with a space so a zero-initialised RAM powers up blank.
    always_ff @(posedge clk_100MHz) begin
        if (wr_en && (wr_addr < c_depth)) begin
            r_text_mem[wr_addr] <= wr_data ^ c_blank_char;
        end
    end

    assign w_char = r_ram_q ^ c_blank_char;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_ram_q     <= '0;
            r_s1_xbit   <= '0;
            r_s1_yrow   <= '0;
            r_s1_von    <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_cursor <= 1'b0;
            r_s2_xbit   <= '0;
            r_s2_inv    <= 1'b0;
            r_s2_von    <= 1'b0;
            r_s2_hs     <= 1'b0;
            r_s2_vs     <= 1'b0;
            r_s2_cursor <= 1'b0;
            r_rgb       <= '0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
        end else if (p_tick) begin
            r_ram_q     <= r_text_mem[w_rd_addr_safe];
            r_s1_xbit   <= x[2:0];
            r_s1_yrow   <= y[3:0];
            r_s1_von    <= video_on;
            r_s1_hs     <= hsync_in;
            r_s1_vs     <= vsync_in;
            r_s1_cursor <= w_cursor_hit;
            r_s2_xbit   <= r_s1_xbit;
            r_s2_inv    <= w_char[7];
            r_s2_von    <= r_s1_von;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
            r_s2_cursor <= r_s1_cursor;
            r_rgb       <= r_s2_von ? (w_pix ? FG_RGB : BG_RGB) : 12'h000;
            r_hsync     <= r_s2_hs;
            r_vsync     <= r_s2_vs;
        end
    end

    font_rom_8x16 u_font_rom (
        .clk_100MHz (clk_100MHz),
        .i_en       (p_tick),
        .i_char     (w_char[6:0]),
        .i_row      (r_s1_yrow),
        .o_data     (w_glyph_row)
    );

    assign w_blink_phase = r_frame_cnt[BLINK_BITS-1];
    assign w_pix = w_glyph_row[~r_s2_xbit] ^ r_s2_inv ^ (r_s2_cursor & w_blink_phase);

    // Frame counting runs every clock so short vsync pulses between pixel ticks are not missed.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_vsync_prev <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (vsync_in && !r_vsync_prev) begin
                r_frame_cnt <= r_frame_cnt + {{(BLINK_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rgb   = r_rgb;
    assign hsync = r_hsync;
    assign vsync = r_vsync;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_renderer.sv
//==============================================================================
// Module      : tb_vga_text_renderer
// Description : Directed self-checking bench for vga_text_renderer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_text_renderer;

    localparam logic [11:0] c_fg = 12'hFFF;
    localparam logic [11:0] c_bg = 12'h000;

    logic        clk_100MHz = 1'b0;
    logic        reset, p_tick, video_on, hsync_in, vsync_in;
    logic [9:0]  x, y;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] rgb;
    logic        hsync, vsync;

    int checks   = 0;
    int failures = 0;

    logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

    // Expected outputs for the last three pixel ticks; index 2 is due at the current tick.
    logic [11:0] h_rgb [3];
    logic        h_hs  [3];
    logic        h_vs  [3];
    string       h_tag [3];

    logic        pend_wr;
    logic [11:0] pend_addr;
    logic [7:0]  pend_data;

    always #5 clk_100MHz = ~clk_100MHz;

    vga_text_renderer dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .x          (x),
        .y          (y),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    task automatic check_val(input string tag, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic seed_reset_history();
        for (int i = 0; i < 3; i++) begin
            h_rgb[i] = 12'h000;
            h_hs[i]  = 1'b0;
            h_vs[i]  = 1'b0;
            h_tag[i] = "post_reset";
        end
    endtask

    // One pixel tick: drive inputs, clock them in, check the pixel issued two ticks earlier.
    task automatic pt(input int px, input int py, input logic von, input logic hs, input logic vs,
                      input logic [11:0] exp, input string tag);
        @(negedge clk_100MHz);
        x        = 10'(px);
        y        = 10'(py);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        if (pend_wr) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr;
            wr_data = pend_data;
        end
        @(posedge clk_100MHz);
        #1;
        p_tick  = 1'b0;
        wr_en   = 1'b0;
        pend_wr = 1'b0;
        for (int i = 2; i > 0; i--) begin
            h_rgb[i] = h_rgb[i-1];
            h_hs[i]  = h_hs[i-1];
            h_vs[i]  = h_vs[i-1];
            h_tag[i] = h_tag[i-1];
        end
        h_rgb[0] = exp;
        h_hs[0]  = hs;
        h_vs[0]  = vs;
        h_tag[0] = tag;
        check_val($sformatf("%s_rgb", h_tag[2]), rgb, h_rgb[2]);
        check_val($sformatf("%s_hsync", h_tag[2]), {11'b0, hsync}, {11'b0, h_hs[2]});
        check_val($sformatf("%s_vsync", h_tag[2]), {11'b0, vsync}, {11'b0, h_vs[2]});
        repeat (3) @(posedge clk_100MHz);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) pt(700, 0, 1'b0, 1'b0, 1'b0, 12'h000, "fill");
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk_100MHz);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk_100MHz);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic vsync_edges(input int n);
        for (int i = 0; i < n; i++) begin
            pt(700, 0, 1'b0, 1'b0, 1'b1, 12'h000, "vs_hi");
            pt(700, 0, 1'b0, 1'b0, 1'b0, 12'h000, "vs_lo");
        end
    endtask

    task automatic probe_cursor(input logic [11:0] exp_cur, input string tag);
        pt(40, 32, 1'b1, 1'b0, 1'b0, exp_cur, {tag, "_cursor"});
        pt(48, 32, 1'b1, 1'b0, 1'b0, c_bg, {tag, "_neighbour"});
        fill(2);
    endtask

    initial begin
        logic [7:0] row_bits;
        reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        x = '0; y = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        pend_wr = 1'b0; pend_addr = '0; pend_data = '0;

        // Reset held with live inputs and p_tick pulsing
        @(negedge clk_100MHz);
        reset = 1'b1; video_on = 1'b1; hsync_in = 1'b1; x = 10'd0; y = 10'd7;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100MHz);
            p_tick = (i % 4 == 0);
        end
        @(negedge clk_100MHz);
        check_val("reset_rgb", rgb, 12'h000);
        check_val("reset_hsync", {11'b0, hsync}, 12'h000);
        check_val("reset_vsync", {11'b0, vsync}, 12'h000);
        reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b0;
        seed_reset_history();

        // First pixel after release reaches rgb on its third tick
        wr(12'd0, 8'h41);
        pt(0, 7, 1'b1, 1'b0, 1'b0, c_fg, "lat0");
        pt(1, 7, 1'b1, 1'b0, 1'b0, c_fg, "lat1");
        pt(7, 7, 1'b1, 1'b0, 1'b0, c_bg, "lat7");

        // Glyph 'A' in cell 0, hsync toggling with x
        for (int yy = 0; yy < 16; yy++) begin
            row_bits = glyph_a[yy];
            for (int xx = 0; xx < 8; xx++) begin
                pt(xx, yy, 1'b1, 1'(xx % 2), 1'b0, row_bits[7-xx] ? c_fg : c_bg,
                   $sformatf("A_%0d_%0d", xx, yy));
            end
        end
        fill(2);

        // Mid-frame reset blanks on the very next edge, then realigns
        pt(0, 7, 1'b1, 1'b1, 1'b0, c_fg, "pre_reset");
        fill(2);
        @(negedge clk_100MHz);
        reset = 1'b1;
        @(posedge clk_100MHz);
        #1;
        check_val("midreset_rgb", rgb, 12'h000);
        @(negedge clk_100MHz);
        reset = 1'b0;
        seed_reset_history();
        pt(0, 7, 1'b1, 1'b0, 1'b0, c_fg, "resume0");
        fill(2);

        // Inverse 'A' in the last cell
        wr(12'd2399, 8'hC1);
        for (int yy = 0; yy < 16; yy++) begin
            row_bits = glyph_a[yy];
            for (int xx = 0; xx < 8; xx++) begin
                pt(632 + xx, 464 + yy, 1'b1, 1'b0, 1'b0, row_bits[7-xx] ? c_bg : c_fg,
                   $sformatf("invA_%0d_%0d", xx, yy));
            end
        end
        fill(2);

        // Blanking region over a non-space cell, irregular hsync pattern
        wr(12'd87, 8'h42);
        for (int i = 0; i < 8; i++) begin
            pt(700 + i, 2, 1'b0, 1'((i % 3) == 0), 1'b0, 12'h000, $sformatf("blank_%0d", i));
        end
        fill(2);

        // Cursor blink at col 5, row 2
        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
        probe_cursor(c_bg, "blink0");
        vsync_edges(15);
        probe_cursor(c_bg, "blink15");
        vsync_edges(1);
        probe_cursor(c_fg, "blink16");
        cursor_en = 1'b0;
        probe_cursor(c_bg, "blink16_off");
        cursor_en = 1'b1; cursor_col = 7'd85;
        probe_cursor(c_bg, "blink16_badcol");
        cursor_col = 7'd5;
        vsync_edges(15);
        probe_cursor(c_fg, "blink31");
        vsync_edges(1);
        probe_cursor(c_bg, "blink32");
        cursor_en = 1'b0;

        // Read-first: write addr 10 on the tick that reads it
        pend_wr = 1'b1; pend_addr = 12'd10; pend_data = 8'h41;
        pt(80, 7, 1'b1, 1'b0, 1'b0, c_bg, "rf_old");
        fill(2);
        pt(80, 7, 1'b1, 1'b0, 1'b0, c_fg, "rf_new");
        fill(2);

        // Out-of-range write leaves every cell alone
        wr(12'd3000, 8'h42);
        pt(0, 7, 1'b1, 1'b0, 1'b0, c_fg, "oob_cell0");
        pt(80, 7, 1'b1, 1'b0, 1'b0, c_fg, "oob_cell10");
        pt(632, 471, 1'b1, 1'b0, 1'b0, c_bg, "oob_cell2399");
        pt(576, 183, 1'b1, 1'b0, 1'b0, c_bg, "oob_cell952");
        fill(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
